hes_stream_cipher: RTL and testbench

- Parametrised successor to the byte-serial AES_cipher.
- Transforms a stream of byte lanes using a message key and a per-byte index: encrypt c = SBOX(p ^ k_i), decrypt p = INV_SBOX(c) ^ k_i, where k_i = key ^ i[7:0].
- Adds an encrypt/decrypt mode, LANES bytes per beat, ready/valid backpressure on both sides, and an output buffer.
- Sits between the HES byte-stream front end and the output packer.

---
 rtl/hes_cipher_pkg.sv | 63 ++++++
 rtl/hes_sync_fifo.sv | 57 +++++
 rtl/hes_stream_cipher.sv | 129 ++++++++++++
 tb/tb_hes_stream_cipher.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hes_cipher_pkg.sv
// hes_cipher_pkg: shared types, widths and the AES byte substitution tables
// used by the HES stream cipher.
//   sbox(x)     : AES forward S-box
//   inv_sbox(x) : AES inverse S-box
//   mode_e      : MODE_ENC / MODE_DEC
package hes_cipher_pkg;

    localparam int BYTE_W = 8;
    localparam int IDX_W  = 8;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    // Entry x lives at bits [{~x,3'b000} +: 8]; row 0 is the most significant.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
        128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
        128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8,
        128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
        128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479,
        128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
        128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
        128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
        128'h547b9432_a6c2233d_ee4c950b_42fac34e,
        128'h082ea166_28d924b2_765ba249_6d8bd125,
        128'h72f8f664_86689816_d4a45ccc_5d65b692,
        128'h6c704850_fdedb9da_5e154657_a78d9d84,
        128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
        128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
        128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
        128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
        128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
        128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
        128'h1fdda833_8807c731_b1121059_2780ec5f,
        128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
        128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
        128'h172b047e_ba77d626_e1691463_55210c7d
    };

    function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] x);
        return SBOX_TBL[{~x, 3'b000} +: BYTE_W];
    endfunction

    function automatic logic [BYTE_W-1:0] inv_sbox(input logic [BYTE_W-1:0] x);
        return INV_SBOX_TBL[{~x, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/hes_sync_fifo.sv
// hes_sync_fifo: synchronous FIFO with first-word-fall-through head.
//   clk, reset_n (async, active-high)
//   push_i / wdata_i : write port, ignored when full unless popping this cycle
//   pop_i            : consume head, ignored when empty
//   rdata_o          : current head word (valid while !empty_o)
//   count_o          : number of stored entries
//   empty_o          : no entries stored
module hes_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop on a full FIFO frees the slot the simultaneous push takes.
    assign do_push = push_i && (!full || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hes_stream_cipher.sv
// hes_stream_cipher: LANES-wide byte stream cipher with ready/valid on both
// sides. Lane j of a beat uses index i = idx + j and key k_i = key ^ i:
//   encrypt c = sbox(p ^ k_i), decrypt p = inv_sbox(c) ^ k_i.
// Ports:
//   clk, reset_n (async, active-high)
//   new_message, mode, key : message setup, sampled on the pulse
//   in_valid / in_ready / data_in    : input beats
//   out_valid / out_ready / data_out : output beats from the buffer head
//   out_parity (only with HES_STREAM_CIPHER_PARITY_EN) : per-lane XOR parity
// Optional feature macro: HES_STREAM_CIPHER_PARITY_EN
module hes_stream_cipher
    import hes_cipher_pkg::*;
#(
    parameter int LANES      = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     new_message,
    input  logic                     mode,
    input  logic [BYTE_W-1:0]        key,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*LANES-1:0]  data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*LANES-1:0]  data_out
`ifdef HES_STREAM_CIPHER_PARITY_EN
   ,output logic [LANES-1:0]         out_parity
`endif
);
    localparam int DATA_W = BYTE_W * LANES;
`ifdef HES_STREAM_CIPHER_PARITY_EN
    localparam int WORD_W = DATA_W + LANES;
`else
    localparam int WORD_W = DATA_W;
`endif
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES % 256);

    logic [BYTE_W-1:0] key_q, key_d;
    mode_e             mode_q, mode_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              s1_valid_q;
    logic [WORD_W-1:0] s1_word_q, s1_word_d;
    logic [WORD_W-1:0] hold_q;

    logic [BYTE_W-1:0] eff_key;
    mode_e             eff_mode;
    logic [IDX_W-1:0]  idx_base;
    logic [DATA_W-1:0] lanes_d;
    logic              accept, pop;
    logic [WORD_W-1:0] head_word, out_word;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [CNT_W:0]    occupancy;

    // A beat accepted with the new_message pulse already uses the new setup.
    assign eff_key  = new_message ? key : key_q;
    assign eff_mode = new_message ? mode_e'(mode) : mode_q;
    assign idx_base = new_message ? '0 : idx_q;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [IDX_W-1:0]  lane_idx;
        logic [BYTE_W-1:0] lane_key, din;
        assign lane_idx = idx_base + IDX_W'(j);
        assign lane_key = eff_key ^ lane_idx;
        assign din      = data_in[BYTE_W*j +: BYTE_W];
        assign lanes_d[BYTE_W*j +: BYTE_W] = (eff_mode == MODE_DEC)
                                           ? (inv_sbox(din) ^ lane_key)
                                           : sbox(din ^ lane_key);
`ifdef HES_STREAM_CIPHER_PARITY_EN
        assign s1_word_d[DATA_W + j] = ^lanes_d[BYTE_W*j +: BYTE_W];
`endif
    end

    assign s1_word_d[DATA_W-1:0] = lanes_d;

    // Credit check counts the stage-1 beat too, so stage-1 always has room.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid_q};
    assign in_ready  = !reset_n && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;

    assign key_d  = new_message ? key : key_q;
    assign mode_d = eff_mode;
    assign idx_d  = accept ? (idx_base + IDX_STEP) : idx_base;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            key_q      <= '0;
            mode_q     <= MODE_ENC;
            idx_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_word_q  <= '0;
            hold_q     <= '0;
        end else begin
            key_q      <= key_d;
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            s1_valid_q <= accept;
            if (accept) s1_word_q <= s1_word_d;
            if (pop)    hold_q    <= head_word;
        end
    end

    hes_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (s1_valid_q),
        .wdata_i (s1_word_q),
        .pop_i   (pop),
        .rdata_o (head_word),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    // With the buffer empty the output keeps the last word that left it.
    assign out_word  = out_valid ? head_word : hold_q;
    assign data_out  = out_word[DATA_W-1:0];
`ifdef HES_STREAM_CIPHER_PARITY_EN
    assign out_parity = out_word[WORD_W-1:DATA_W];
`endif

endmodule

// File: tb/tb_hes_stream_cipher.sv
module tb_hes_stream_cipher;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        new_message1, mode1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [7:0]  key1, data_in1, data_out1;
    logic        new_message4, mode4, in_valid4, in_ready4, out_valid4, out_ready4;
    logic [7:0]  key4;
    logic [31:0] data_in4, data_out4;
`ifdef HES_STREAM_CIPHER_PARITY_EN
    logic [0:0]  out_parity1;
    logic [3:0]  out_parity4;
`endif

    int n_chk = 0;
    int n_bad = 0;
    int acc1  = 0;
    logic [7:0]  q1[$];
    logic [31:0] q4[$];
    logic [7:0]  pt[10] = '{8'h42, 8'h00, 8'h01, 8'hff, 8'h80, 8'h7f, 8'h5a, 8'ha5, 8'h3c, 8'hc3};
    logic [7:0]  ct[10];

    always #5 clk = ~clk;

    hes_stream_cipher #(.LANES(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .new_message(new_message1), .mode(mode1),
        .key(key1), .in_valid(in_valid1), .in_ready(in_ready1), .data_in(data_in1),
        .out_valid(out_valid1), .out_ready(out_ready1), .data_out(data_out1)
`ifdef HES_STREAM_CIPHER_PARITY_EN
       ,.out_parity(out_parity1)
`endif
    );

    hes_stream_cipher #(.LANES(4), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .new_message(new_message4), .mode(mode4),
        .key(key4), .in_valid(in_valid4), .in_ready(in_ready4), .data_in(data_in4),
        .out_valid(out_valid4), .out_ready(out_ready4), .data_out(data_out4)
`ifdef HES_STREAM_CIPHER_PARITY_EN
       ,.out_parity(out_parity4)
`endif
    );

    // Handshakes are sampled mid-cycle; they take effect on the next rising edge.
    always @(negedge clk) begin
        if (out_valid1 && out_ready1) q1.push_back(data_out1);
        if (out_valid4 && out_ready4) q4.push_back(data_out4);
        if (in_valid1 && in_ready1) acc1++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive1(input logic [7:0] d, input logic nm, input logic md, input logic [7:0] k);
        int n = 0;
        in_valid1 = 1'b1; data_in1 = d; new_message1 = nm; mode1 = md; key1 = k;
        @(negedge clk);
        while (!in_ready1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("accept_tmo", {31'd0, in_ready1}, 32'd1);
        @(posedge clk); #1;
        in_valid1 = 1'b0; new_message1 = 1'b0;
    endtask

    task automatic wait_out1(input int n);
        int t = 0;
        while (q1.size() < n && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        if (q1.size() < n) chk("out1_tmo", q1.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        new_message1 = 0; mode1 = 0; key1 = 0; in_valid1 = 0; data_in1 = 0; out_ready1 = 1;
        new_message4 = 0; mode4 = 0; key4 = 0; in_valid4 = 0; data_in4 = 0; out_ready4 = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready1}, 0);
        chk("rst_out_valid", {31'd0, out_valid1}, 0);
        chk("rst_data_out", {24'd0, data_out1}, 0);
        @(negedge clk); reset_n = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", {31'd0, in_ready1}, 1);

        // Encrypt, key 0x11, indices 0,1,2
        drive1(8'h42, 1, 0, 8'h11);
        chk("lat_cycle1", {31'd0, out_valid1}, 0);
        drive1(8'h00, 0, 0, 8'h00);
        chk("lat_cycle2", {31'd0, out_valid1}, 1);
        chk("lat_data", {24'd0, data_out1}, 32'hED);
        drive1(8'h01, 0, 0, 8'h00);
        wait_out1(3);
        chk("enc0", {24'd0, q1[0]}, 32'hED);
        chk("enc1", {24'd0, q1[1]}, 32'hCA);
        chk("enc2", {24'd0, q1[2]}, 32'hC9);
        q1.delete();

        // Decrypt
        drive1(8'hED, 1, 1, 8'h11);
        wait_out1(1);
        chk("dec0", {24'd0, q1[0]}, 32'h42);
        q1.delete();

        // Round trip through the device
        for (int i = 0; i < 10; i++) drive1(pt[i], (i == 0), 0, 8'h6B);
        wait_out1(10);
        for (int i = 0; i < 10; i++) ct[i] = q1[i];
        q1.delete();
        for (int i = 0; i < 10; i++) drive1(ct[i], (i == 0), 1, 8'h6B);
        wait_out1(10);
        for (int i = 0; i < 10; i++) chk($sformatf("rt%0d", i), {24'd0, q1[i]}, {24'd0, pt[i]});
        q1.delete();

        // Backpressure: 8 cycles of in_valid with sink stalled
        out_ready1 = 1'b0; acc1 = 0;
        in_valid1 = 1'b1; data_in1 = 8'h00; new_message1 = 1'b1; key1 = 8'h00; mode1 = 1'b0;
        @(posedge clk); #1;
        new_message1 = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        in_valid1 = 1'b0;
        chk("bp_accepts", acc1, 4);
        chk("bp_in_ready", {31'd0, in_ready1}, 0);
        chk("bp_out_valid", {31'd0, out_valid1}, 1);
        chk("bp_head_stable", {24'd0, data_out1}, 32'h63);
        out_ready1 = 1'b1;
        wait_out1(4);
        chk("bp_d0", {24'd0, q1[0]}, 32'h63);
        chk("bp_d1", {24'd0, q1[1]}, 32'h7C);
        chk("bp_d2", {24'd0, q1[2]}, 32'h77);
        chk("bp_d3", {24'd0, q1[3]}, 32'h7B);
        repeat (3) begin @(posedge clk); #1; end
        chk("bp_no_dup", q1.size(), 4);
        chk("bp_empty", {31'd0, out_valid1}, 0);
        chk("bp_hold", {24'd0, data_out1}, 32'h7B);
        q1.delete();

        // Index wrap: 257 zero bytes with key 0
        for (int i = 0; i < 257; i++) drive1(8'h00, (i == 0), 0, 8'h00);
        wait_out1(257);
        chk("wrap_1", {24'd0, q1[1]}, 32'h7C);
        chk("wrap_255", {24'd0, q1[255]}, 32'h16);
        chk("wrap_256", {24'd0, q1[256]}, 32'h63);
        q1.delete();

        // new_message mid-stream: older beats keep key 0
        drive1(8'h00, 1, 0, 8'h00);
        drive1(8'h00, 0, 0, 8'h00);
        drive1(8'h42, 1, 0, 8'h11);
        drive1(8'h00, 0, 0, 8'h00);
        wait_out1(4);
        chk("mid_old0", {24'd0, q1[0]}, 32'h63);
        chk("mid_old1", {24'd0, q1[1]}, 32'h7C);
        chk("mid_new", {24'd0, q1[2]}, 32'hED);
        chk("mid_next", {24'd0, q1[3]}, 32'hCA);
        q1.delete();

        // Four lanes per beat
        in_valid4 = 1'b1; data_in4 = 32'h01010100; new_message4 = 1'b1; key4 = 8'h11;
        @(posedge clk); #1;
        new_message4 = 1'b0;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        for (int t = 0; t < 20 && q4.size() < 2; t++) begin @(posedge clk); #1; end
        chk("l4_count", q4.size(), 2);
        if (q4.size() >= 2) begin
            chk("l4_beat0", q4[0], 32'h7DC98282);
            chk("l4_beat1", q4[1], 32'hF0475959);
        end

        // Async reset with beats buffered
        out_ready1 = 1'b0;
        drive1(8'h00, 1, 0, 8'h11);
        drive1(8'h00, 0, 0, 8'h00);
        drive1(8'h00, 0, 0, 8'h00);
        repeat (2) begin @(posedge clk); #1; end
        chk("pre_rst_valid", {31'd0, out_valid1}, 1);
        #2 reset_n = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid1}, 0);
        chk("rst_mid_ready", {31'd0, in_ready1}, 0);
        @(negedge clk); reset_n = 1'b0; out_ready1 = 1'b1;
        @(posedge clk); #1;
        q1.delete();
        drive1(8'h00, 0, 0, 8'h00);
        wait_out1(1);
        repeat (3) begin @(posedge clk); #1; end
        chk("post_rst_count", q1.size(), 1);
        if (q1.size() >= 1) chk("post_rst_data", {24'd0, q1[0]}, 32'h63);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
